// File: rtl/dram_rd_data_que.sv
// DRAM read-return queue: buffers 256-bit entries with their request tags and
// replays each entry to the CPU side as four 64-bit beats.
//
// Handshake: a beat transfers on every rising edge where rd_vld && rd_ack;
// rd_vld never drops while an entry is pending and the beat is held stable
// until it is acknowledged. The write side has no ready: wr_vld while full is
// dropped and latched in ovfl_err.
module dram_rd_data_que #(
  parameter int DEPTH = 8,
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [255:0] wr_data,
  input  logic [3:0]   wr_id,
  output logic         wr_full,
  output logic [4:0]   free_cnt,
  output logic         rd_vld,
  output logic [63:0]  rd_data,
  output logic [3:0]   rd_id,
  output logic         rd_last,
  input  logic         rd_ack,
  output logic         ovfl_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 64 * BEATS;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  logic [DW+3:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, count, count_nxt;
  logic [1:0]    beat;
  state_t        state, state_nxt;
  logic          wr_acc, beat_ack, pop;
  logic [DW+3:0] head;

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + CW'(1);
  endfunction

  // Acceptance looks only at the pre-edge count, so a same-cycle pop never
  // frees a slot for a write that arrives while full.
  assign wr_acc   = wr_vld && (count < CW'(DEPTH));
  assign beat_ack = (state == SEND) && rd_ack;
  assign pop      = beat_ack && (beat == 2'(BEATS - 1));

  always_comb begin
    count_nxt = count;
    case ({wr_acc, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Entry storage carries no reset; stale contents are never visible because
  // rd_data/rd_id are gated by rd_vld.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= {wr_id, wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat     <= '0;
      state    <= EMPTY;
      ovfl_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (beat_ack) beat <= beat + 2'd1;
      if (wr_vld && !wr_acc) ovfl_err <= 1'b1;
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (count_nxt != '0) state_nxt = SEND;
      SEND:    if (pop && (count_nxt == '0)) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign rd_vld   = (state == SEND);
  assign rd_data  = rd_vld ? head[{beat, 6'b0} +: 64] : '0;
  assign rd_id    = rd_vld ? head[DW+3:DW] : '0;
  assign rd_last  = rd_vld && (beat == 2'(BEATS - 1));
  assign wr_full  = (count == CW'(DEPTH));
  assign free_cnt = 5'(DEPTH) - 5'(count);

endmodule
